// File: rtl/lcd_hex_writer.sv
// lcd_hex_writer
//   Drives a 16x2 HD44780 character LCD over its 8-bit, write-only bus.
//   After reset it waits for the panel to power up and sends the init
//   commands. It then redraws two lines on each start request:
//     line 1: "PC:hhhhhhhh"   line 2: "RG:hhhhhhhh S"  (S = F finished, E executing)
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   PWRUP  | post-reset idle period before the first LCD command
//   INIT   | sending 0x38, 0x0C, 0x06, 0x01 (function set .. clear)
//   IDLE   | ready; a start or pending request launches a redraw
//   DRAW   | sending the 26 bytes of a full redraw
//
//   Each byte runs through SETUP (1 cycle, en=0) -> PULSE (EN_CYCLES,
//   en=1) -> WAIT (CMD_WAIT, or CLR_WAIT after the clear command).
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active low
//   start      redraw request, sampled every cycle
//   pc         value shown on line 1
//   value      value shown on line 2
//   final_flag execution-finished flag, selects the status character
//              (named final_flag because "final" is a reserved word)
//   busy       high during power-up, init and redraw
//   done       one-cycle pulse when a redraw completes
//   LCD_en     LCD enable strobe
//   LCD_rw     LCD read/write, always write (0)
//   LCD_rs     0 = command, 1 = data
//   LCD_blon   backlight enable
//   LCD_data   LCD data bus
module lcd_hex_writer #(
   parameter int PWRUP_CYCLES = 750000,
   parameter int EN_CYCLES    = 25,
   parameter int CMD_WAIT     = 2500,
   parameter int CLR_WAIT     = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] pc,
   input  logic [31:0] value,
   input  logic        final_flag,
   output logic        busy,
   output logic        done,
   output logic        LCD_en,
   output logic        LCD_rw,
   output logic        LCD_rs,
   output logic        LCD_blon,
   output logic [7:0]  LCD_data
);

   typedef enum logic [1:0] {T_PWRUP, T_INIT, T_IDLE, T_DRAW} top_t;
   typedef enum logic [1:0] {B_SETUP, B_PULSE, B_WAIT} byte_t;

   localparam logic [31:0] PWRUP_TC = 32'(PWRUP_CYCLES - 1);
   localparam logic [31:0] EN_TC    = 32'(EN_CYCLES - 1);
   localparam logic [31:0] CMD_TC   = 32'(CMD_WAIT - 1);
   localparam logic [31:0] CLR_TC   = 32'(CLR_WAIT - 1);

   top_t        top_q, top_d;
   byte_t       byte_q, byte_d;
   logic [4:0]  idx_q, idx_d;
   logic [31:0] cnt_q, cnt_d;
   logic        pending_q, pending_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] value_q, value_d;
   logic        final_q, final_d;
   logic        done_q, done_d;
   logic        rs_q, rs_d;
   logic [7:0]  data_q, data_d;
   logic        blon_q, blon_d;

   logic [4:0]  nxt_idx;
   logic [31:0] wait_tc;
   logic [4:0]  last_idx;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      hex_char = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   function automatic logic [7:0] init_byte(input logic [1:0] i);
      case (i)
         2'd0:    init_byte = 8'h38;
         2'd1:    init_byte = 8'h0C;
         2'd2:    init_byte = 8'h06;
         default: init_byte = 8'h01;
      endcase
   endfunction

   function automatic logic [7:0] draw_byte(input logic [4:0] i, input logic [31:0] p,
                                            input logic [31:0] v, input logic f);
      case (i)
         5'd0:    draw_byte = 8'h80;
         5'd1:    draw_byte = 8'h50;
         5'd2:    draw_byte = 8'h43;
         5'd3:    draw_byte = 8'h3A;
         5'd4:    draw_byte = hex_char(p[31:28]);
         5'd5:    draw_byte = hex_char(p[27:24]);
         5'd6:    draw_byte = hex_char(p[23:20]);
         5'd7:    draw_byte = hex_char(p[19:16]);
         5'd8:    draw_byte = hex_char(p[15:12]);
         5'd9:    draw_byte = hex_char(p[11:8]);
         5'd10:   draw_byte = hex_char(p[7:4]);
         5'd11:   draw_byte = hex_char(p[3:0]);
         5'd12:   draw_byte = 8'hC0;
         5'd13:   draw_byte = 8'h52;
         5'd14:   draw_byte = 8'h47;
         5'd15:   draw_byte = 8'h3A;
         5'd16:   draw_byte = hex_char(v[31:28]);
         5'd17:   draw_byte = hex_char(v[27:24]);
         5'd18:   draw_byte = hex_char(v[23:20]);
         5'd19:   draw_byte = hex_char(v[19:16]);
         5'd20:   draw_byte = hex_char(v[15:12]);
         5'd21:   draw_byte = hex_char(v[11:8]);
         5'd22:   draw_byte = hex_char(v[7:4]);
         5'd23:   draw_byte = hex_char(v[3:0]);
         5'd24:   draw_byte = 8'h20;
         default: draw_byte = f ? 8'h46 : 8'h45;
      endcase
   endfunction

   assign nxt_idx  = idx_q + 5'd1;
   // Only the clear command needs the long settle time.
   assign wait_tc  = (!rs_q && data_q == 8'h01) ? CLR_TC : CMD_TC;
   assign last_idx = (top_q == T_INIT) ? 5'd3 : 5'd25;

   always_comb begin
      top_d     = top_q;
      byte_d    = byte_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      pending_d = pending_q | (start && top_q != T_IDLE);
      pc_d      = pc_q;
      value_d   = value_q;
      final_d   = final_q;
      done_d    = 1'b0;
      rs_d      = rs_q;
      data_d    = data_q;
      blon_d    = 1'b1;

      case (top_q)
         T_PWRUP: begin
            if (cnt_q == PWRUP_TC) begin
               top_d  = T_INIT;
               byte_d = B_SETUP;
               idx_d  = 5'd0;
               cnt_d  = 32'd0;
               rs_d   = 1'b0;
               data_d = init_byte(2'd0);
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         T_IDLE: begin
            if (start || pending_q) begin
               top_d     = T_DRAW;
               byte_d    = B_SETUP;
               idx_d     = 5'd0;
               cnt_d     = 32'd0;
               pending_d = 1'b0;
               pc_d      = pc;
               value_d   = value;
               final_d   = final_flag;
               rs_d      = 1'b0;
               data_d    = 8'h80;
            end
         end
         default: begin
            case (byte_q)
               B_SETUP: begin
                  byte_d = B_PULSE;
                  cnt_d  = 32'd0;
               end
               B_PULSE: begin
                  if (cnt_q == EN_TC) begin
                     byte_d = B_WAIT;
                     cnt_d  = 32'd0;
                  end else begin
                     cnt_d = cnt_q + 32'd1;
                  end
               end
               default: begin
                  if (cnt_q == wait_tc) begin
                     cnt_d = 32'd0;
                     if (idx_q == last_idx) begin
                        top_d  = T_IDLE;
                        done_d = (top_q == T_DRAW);
                     end else begin
                        idx_d  = nxt_idx;
                        byte_d = B_SETUP;
                        // Next byte is presented on the bus from its SETUP cycle.
                        if (top_q == T_INIT) begin
                           rs_d   = 1'b0;
                           data_d = init_byte(nxt_idx[1:0]);
                        end else begin
                           rs_d   = (nxt_idx != 5'd0) && (nxt_idx != 5'd12);
                           data_d = draw_byte(nxt_idx, pc_q, value_q, final_q);
                        end
                     end
                  end else begin
                     cnt_d = cnt_q + 32'd1;
                  end
               end
            endcase
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         top_q     <= T_PWRUP;
         byte_q    <= B_SETUP;
         idx_q     <= 5'd0;
         cnt_q     <= 32'd0;
         pending_q <= 1'b0;
         pc_q      <= 32'd0;
         value_q   <= 32'd0;
         final_q   <= 1'b0;
         done_q    <= 1'b0;
         rs_q      <= 1'b0;
         data_q    <= 8'h00;
         blon_q    <= 1'b0;
      end else begin
         top_q     <= top_d;
         byte_q    <= byte_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         pc_q      <= pc_d;
         value_q   <= value_d;
         final_q   <= final_d;
         done_q    <= done_d;
         rs_q      <= rs_d;
         data_q    <= data_d;
         blon_q    <= blon_d;
      end
   end

   // en decoded from registered state so an async reset drops it at once.
   assign LCD_en   = (top_q == T_INIT || top_q == T_DRAW) && (byte_q == B_PULSE);
   assign busy     = (top_q != T_IDLE);
   assign done     = done_q;
   assign LCD_rw   = 1'b0;
   assign LCD_rs   = rs_q;
   assign LCD_data = data_q;
   assign LCD_blon = blon_q;

endmodule

// File: tb/tb_lcd_hex_writer.sv
module tb_lcd_hex_writer;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] pc;
   logic [31:0] value;
   logic        final_flag;
   logic        busy, done, LCD_en, LCD_rw, LCD_rs, LCD_blon;
   logic [7:0]  LCD_data;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;

   logic [8:0]  q_b[$];
   int          q_r[$];
   int          q_w[$];
   logic [8:0]  exp_q[$];

   logic        prev_en = 1'b0;
   logic        prev_rs = 1'b0;
   logic [7:0]  prev_data = 8'h00;
   int          wcnt = 0;

   lcd_hex_writer #(
      .PWRUP_CYCLES(16), .EN_CYCLES(2), .CMD_WAIT(4), .CLR_WAIT(8)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .pc(pc), .value(value),
      .final_flag(final_flag), .busy(busy), .done(done), .LCD_en(LCD_en),
      .LCD_rw(LCD_rw), .LCD_rs(LCD_rs), .LCD_blon(LCD_blon), .LCD_data(LCD_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bus monitor: captures bytes on en rise, pulse widths, protocol rules.
   always @(negedge clk) begin
      chk("rw_zero", {31'd0, LCD_rw}, 32'd0);
      if (LCD_en && prev_en)
         chk("bus_stable", {23'd0, LCD_rs, LCD_data}, {23'd0, prev_rs, prev_data});
      if (done || !busy)
         chk("en_low_when_idle", {31'd0, LCD_en}, 32'd0);
      if (LCD_en && !prev_en) begin
         q_b.push_back({LCD_rs, LCD_data});
         q_r.push_back(cyc);
      end
      if (LCD_en) wcnt++;
      else if (prev_en) begin
         q_w.push_back(wcnt);
         wcnt = 0;
      end
      if (done) done_cnt++;
      prev_en   = LCD_en;
      prev_rs   = LCD_rs;
      prev_data = LCD_data;
   end

   task automatic clear_q();
      q_b.delete();
      q_r.delete();
      q_w.delete();
   endtask

   task automatic build_exp(input string l1, input string l2);
      exp_q.delete();
      exp_q.push_back({1'b0, 8'h80});
      for (int i = 0; i < l1.len(); i++) exp_q.push_back({1'b1, l1[i]});
      exp_q.push_back({1'b0, 8'hC0});
      for (int i = 0; i < l2.len(); i++) exp_q.push_back({1'b1, l2[i]});
   endtask

   task automatic cmp_draw(input string tag, input int base);
      chk({tag, "_nbytes"}, q_b.size(), base + 26);
      for (int i = 0; i < 26; i++) begin
         logic [8:0] got;
         got = (base + i < q_b.size()) ? q_b[base + i] : 9'h1FF;
         chk($sformatf("%s_b%0d", tag, i), {23'd0, got}, {23'd0, exp_q[i]});
      end
   endtask

   task automatic wait_done(input string tag, input int limit);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < limit);
      chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
   endtask

   task automatic wait_idle(input string tag, input int limit);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < limit);
      chk({tag, "_idle_seen"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      int c0, s, dc;
      logic [7:0] ch;
      logic [7:0] init_exp[4];
      init_exp[0] = 8'h38; init_exp[1] = 8'h0C; init_exp[2] = 8'h06; init_exp[3] = 8'h01;

      start = 1'b0; pc = 32'd0; value = 32'd0; final_flag = 1'b0;
      rst = 1'b1;
      #2 rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd1);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_en", {31'd0, LCD_en}, 32'd0);
      chk("rst_rs", {31'd0, LCD_rs}, 32'd0);
      chk("rst_data", {24'd0, LCD_data}, 32'd0);
      chk("rst_blon", {31'd0, LCD_blon}, 32'd0);
      @(negedge clk);
      clear_q();
      rst = 1'b1;
      c0 = cyc;

      // Power-up and init sequence
      @(negedge clk);
      chk("blon_on", {31'd0, LCD_blon}, 32'd1);
      wait_idle("init", 200);
      chk("init_nbytes", q_b.size(), 4);
      if (q_r.size() > 0) chk("pwrup_delay", q_r[0] - c0, 17);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("init_b%0d", i), (i < q_b.size()) ? {23'd0, q_b[i]} : 32'h1FF,
             {24'd0, init_exp[i]});
         chk($sformatf("init_w%0d", i), (i < q_w.size()) ? q_w[i] : -1, 2);
      end
      if (q_r.size() > 3) chk("clr_wait", cyc - q_r[3], 10);

      // Draw: DEADBEEF, finished
      clear_q();
      pc = 32'h0000_00A4; value = 32'hDEAD_BEEF; final_flag = 1'b1;
      s = cyc;
      pulse_start();
      wait_done("draw1", 400);
      chk("draw1_latency", cyc - s, 183);
      chk("draw1_busy", {31'd0, busy}, 32'd0);
      build_exp("PC:000000A4", "RG:DEADBEEF F");
      cmp_draw("draw1", 0);
      repeat (5) @(negedge clk);
      chk("draw1_done_once", done_cnt, 1);

      // Draw: zero value, executing
      clear_q();
      pc = 32'h9ABC_DEF0; value = 32'h0; final_flag = 1'b0;
      pulse_start();
      wait_done("draw2", 400);
      build_exp("PC:9ABCDEF0", "RG:00000000 E");
      cmp_draw("draw2", 0);
      for (int i = 4; i < 24; i++) begin
         if ((i >= 4 && i <= 11) || i >= 16) begin
            ch = (i < q_b.size()) ? q_b[i][7:0] : 8'h00;
            chk($sformatf("hex_range%0d", i), {31'd0, (ch >= 8'h30 && ch <= 8'h46)}, 32'd1);
         end
      end

      // Three starts during a draw collapse into one redraw with new values
      repeat (3) @(negedge clk);
      clear_q();
      dc = done_cnt;
      pc = 32'h1111_1111; value = 32'h2222_2222; final_flag = 1'b1;
      pulse_start();
      repeat (20) @(negedge clk);
      pc = 32'h0BAD_F00D; value = 32'hCAFE_0123; final_flag = 1'b0;
      pulse_start();
      repeat (30) @(negedge clk);
      pulse_start();
      repeat (50) @(negedge clk);
      pulse_start();
      wait_done("multi_a", 400);
      build_exp("PC:11111111", "RG:22222222 F");
      cmp_draw("multi_a", 0);
      @(negedge clk);
      chk("multi_redraw_busy", {31'd0, busy}, 32'd1);
      wait_done("multi_b", 400);
      build_exp("PC:0BADF00D", "RG:CAFE0123 E");
      cmp_draw("multi_b", 26);
      repeat (250) @(negedge clk);
      chk("multi_done_count", done_cnt - dc, 2);
      chk("multi_no_third", q_b.size(), 52);
      chk("multi_idle", {31'd0, busy}, 32'd0);

      // Reset in the middle of an enable pulse
      pulse_start();
      begin
         int n;
         n = 0;
         while (!LCD_en && n < 50) begin
            @(negedge clk);
            n++;
         end
      end
      chk("pre_rst_en", {31'd0, LCD_en}, 32'd1);
      rst = 1'b0;
      #1;
      chk("rst_en_drop", {31'd0, LCD_en}, 32'd0);
      chk("rst_busy_mid", {31'd0, busy}, 32'd1);
      repeat (3) @(negedge clk);
      clear_q();
      dc = done_cnt;
      rst = 1'b1;
      wait_idle("reinit", 200);
      chk("reinit_nbytes", q_b.size(), 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("reinit_b%0d", i), (i < q_b.size()) ? {23'd0, q_b[i]} : 32'h1FF,
             {24'd0, init_exp[i]});
      repeat (20) @(negedge clk);
      chk("reinit_no_done", done_cnt - dc, 0);
      chk("reinit_no_draw", q_b.size(), 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
